// File: rtl/xoodyak_aead_seq.sv
// Purpose: sequences one Xoodyak keyed AEAD session (key, nonce, AD, text blocks, tag) around an external Xoodoo core.
// Latency: 3 + n_blocks permutations plus one cycle per Down/Up step; txt_out is valid the cycle after the txt_in handshake.
// Backpressure: txt_in_ready is raised only in CRYPT_IN and the FSM holds txt_out/txt_out_valid until txt_out_ready.
module xoodyak_aead_seq #(
  parameter int MAX_BLOCKS = 4,
  parameter int CNT_W      = $clog2(MAX_BLOCKS + 1),
  parameter int TAG_W      = 128
) (
  input  logic             eph1,
  input  logic             reset,
  input  logic             start,
  input  logic             opmode,
  input  logic [127:0]     key,
  input  logic [127:0]     nonce,
  input  logic [127:0]     assodata,
  input  logic [CNT_W-1:0] n_blocks,
  input  logic [TAG_W-1:0] verification_data,
  input  logic [191:0]     txt_in,
  input  logic             txt_in_valid,
  output logic             txt_in_ready,
  output logic [191:0]     txt_out,
  output logic             txt_out_valid,
  input  logic             txt_out_ready,
  output logic             perm_start,
  output logic [383:0]     perm_state_o,
  input  logic [383:0]     perm_state_i,
  input  logic             perm_done,
  output logic [TAG_W-1:0] authdata,
  output logic             busy,
  output logic             done,
  output logic             verify
);

  typedef enum logic [3:0] {
    S_IDLE, S_KEY, S_NONCE, S_AD, S_CRYPT_UP, S_CRYPT_IN,
    S_CRYPT_OUT, S_TAG, S_PERM_WAIT, S_DONE
  } fsm_t;

  fsm_t             fsm;
  fsm_t             wait_src;   // which Up issued the permutation in flight
  logic [383:0]     st;
  logic             op_lat;
  logic [127:0]     key_lat;
  logic [127:0]     nonce_lat;
  logic [127:0]     ad_lat;
  logic [TAG_W-1:0] vd_lat;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] blk_cnt;

  logic [CNT_W-1:0] n_clamp;
  logic [191:0]     ks_xor;
  logic [191:0]     plain;
  logic             in_fire;
  logic             out_fire;
  logic             last_blk;
  logic [7:0]       up_cu;

  // Down: absorb X, pad byte L with 0x01, and apply the domain byte to byte 47.
  function automatic logic [383:0] down_f(input logic [383:0] s, input logic [383:0] x,
                                          input logic [5:0] len, input logic [7:0] cd);
    logic [383:0] r;
    r = s ^ x;
    r[{len, 3'b000} +: 8] = r[{len, 3'b000} +: 8] ^ 8'h01;
    r[383:376] = r[383:376] ^ cd;
    return r;
  endfunction

  assign n_clamp  = (n_blocks > CNT_W'(MAX_BLOCKS)) ? CNT_W'(MAX_BLOCKS) : n_blocks;
  assign ks_xor   = txt_in ^ st[191:0];
  // The sponge always absorbs plaintext, whichever direction the text flows.
  assign plain    = op_lat ? ks_xor : txt_in;
  assign in_fire  = txt_in_valid && txt_in_ready;
  assign out_fire = txt_out_valid && txt_out_ready;
  assign last_blk = ((blk_cnt + CNT_W'(1)) == n_lat);

  // Up domain byte for the state currently issuing a permutation.
  always_comb begin
    up_cu = 8'h00;
    if (fsm == S_TAG) begin
      up_cu = 8'h40;
    end else if ((fsm == S_CRYPT_UP) && (blk_cnt == '0)) begin
      up_cu = 8'h80;
    end
  end

  // Session FSM with all outputs registered.
  always_ff @(posedge eph1) begin
    if (reset) begin
      fsm           <= S_IDLE;
      wait_src      <= S_IDLE;
      st            <= '0;
      op_lat        <= 1'b0;
      key_lat       <= '0;
      nonce_lat     <= '0;
      ad_lat        <= '0;
      vd_lat        <= '0;
      n_lat         <= '0;
      blk_cnt       <= '0;
      txt_in_ready  <= 1'b0;
      txt_out       <= '0;
      txt_out_valid <= 1'b0;
      perm_start    <= 1'b0;
      perm_state_o  <= '0;
      authdata      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      verify        <= 1'b0;
    end else begin
      perm_start <= 1'b0;
      done       <= 1'b0;
      case (fsm)
        S_IDLE: begin
          if (start) begin
            op_lat    <= opmode;
            key_lat   <= key;
            nonce_lat <= nonce;
            ad_lat    <= assodata;
            vd_lat    <= verification_data;
            n_lat     <= n_clamp;
            st        <= '0;
            blk_cnt   <= '0;
            authdata  <= '0;
            verify    <= 1'b0;
            busy      <= 1'b1;
            fsm       <= S_KEY;
          end
        end
        S_KEY: begin
          st  <= down_f(st, {256'd0, key_lat}, 6'd17, 8'h02);
          fsm <= S_NONCE;
        end
        S_NONCE, S_AD, S_CRYPT_UP, S_TAG: begin
          perm_state_o <= st ^ {up_cu, 376'd0};
          perm_start   <= 1'b1;
          wait_src     <= fsm;
          fsm          <= S_PERM_WAIT;
        end
        S_PERM_WAIT: begin
          if (perm_done) begin
            case (wait_src)
              S_NONCE: begin
                st  <= down_f(perm_state_i, {256'd0, nonce_lat}, 6'd16, 8'h03);
                fsm <= S_AD;
              end
              S_AD: begin
                st  <= down_f(perm_state_i, {256'd0, ad_lat}, 6'd16, 8'h03);
                fsm <= (n_lat == '0) ? S_TAG : S_CRYPT_UP;
              end
              S_CRYPT_UP: begin
                st           <= perm_state_i;
                txt_in_ready <= 1'b1;
                fsm          <= S_CRYPT_IN;
              end
              default: begin
                st       <= perm_state_i;
                authdata <= perm_state_i[TAG_W-1:0];
                verify   <= op_lat ? (perm_state_i[TAG_W-1:0] == vd_lat) : 1'b1;
                done     <= 1'b1;
                busy     <= 1'b0;
                fsm      <= S_DONE;
              end
            endcase
          end
        end
        S_CRYPT_IN: begin
          if (in_fire) begin
            txt_out       <= ks_xor;
            st            <= down_f(st, {192'd0, plain}, 6'd24, 8'h00);
            txt_in_ready  <= 1'b0;
            txt_out_valid <= 1'b1;
            fsm           <= S_CRYPT_OUT;
          end
        end
        S_CRYPT_OUT: begin
          if (out_fire) begin
            txt_out_valid <= 1'b0;
            blk_cnt       <= blk_cnt + CNT_W'(1);
            fsm           <= last_blk ? S_TAG : S_CRYPT_UP;
          end
        end
        S_DONE: begin
          fsm <= S_IDLE;
        end
        default: begin
          fsm <= S_IDLE;
        end
      endcase
    end
  end

endmodule
